mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter, the successor to the fixed 4-bit loadable binary counter with master reset and carry out. Adds configurable width and modulus, runtime count direction, two-input cascade enable (ENP/ENT), synchronous clear, a registered wrap pulse and a sticky overflow flag. Used standalone or chained via CO→ENT to build wider or mixed-radix counters (e.g. BCD timers) in the lab designs.

---
 rtl/counter_pkg.sv | 17 +
 rtl/mod_next_count.sv | 40 ++++
 rtl/mod_updown_counter.sv | 83 ++++++++
 tb/tb_mod_updown_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Lets a parent size a counter from its modulus, e.g. WIDTH = clog2(MODULUS).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_next_count.sv
// Combinational next-count step for a modulo-MODULUS counter in either direction.
module mod_next_count
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] incr;

    // The increment carries into the extra bit, so MODULUS == 2**WIDTH still
    // detects the wrap instead of silently truncating to zero.
    always_comb begin
        incr   = {1'b0, q} + (WIDTH + 1)'(1);
        next_q = '0;
        wrap   = 1'b0;
        if (up == DIR_UP) begin
            if (incr == MOD_EXT) begin
                next_q = '0;
                wrap   = 1'b1;
            end else begin
                next_q = incr[WIDTH-1:0];
            end
        end else if (q == '0) begin
            next_q = MAX_Q;
            wrap   = 1'b1;
        end else begin
            next_q = q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised loadable up/down counter with ENP/ENT cascade enables,
// synchronous clear, registered wrap pulse and sticky overflow flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 2 ** WIDTH,
    parameter int RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             SCLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CO,
    output logic             WRAP,
    output logic             OVF
);

    if (WIDTH < 2) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be at least 2");
    end
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
        $error("mod_updown_counter: RESET_VALUE must be below MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_next;
    logic             count_wrap;
    logic [WIDTH-1:0] load_value;

    mod_next_count #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_count (
        .q      (Q),
        .up     (UP),
        .next_q (count_next),
        .wrap   (count_wrap)
    );

    // Out-of-range load data saturates so Q never leaves 0..MODULUS-1.
    assign load_value = ({1'b0, D} < MOD_EXT) ? D : MAX_Q;

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            Q    <= RST_Q;
            WRAP <= 1'b0;
            OVF  <= 1'b0;
        end else if (!SCLR) begin
            Q    <= '0;
            WRAP <= 1'b0;
            OVF  <= 1'b0;
        end else if (!LOAD) begin
            Q    <= load_value;
            WRAP <= 1'b0;
        end else if (ENP && ENT) begin
            Q    <= count_next;
            WRAP <= count_wrap;
            if (count_wrap) begin
                OVF <= 1'b1;
            end
        end else begin
            WRAP <= 1'b0;
        end
    end

    // CO ignores ENP so a cascaded stage sees its carry one cycle ahead.
    assign TC = (UP == DIR_DOWN) ? (Q == '0) : (Q == MAX_Q);
    assign CO = TC & ENT;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: directed steps with a queue scoreboard on a decimal
// counter, a two-stage decimal cascade, and a 3-bit full-range counter.
module tb_mod_updown_counter;

    typedef struct packed {
        logic [3:0] q;
        logic       wrap;
        logic       ovf;
        logic       tc;
        logic       co;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal counter, RESET_VALUE 3
    logic       a_mr = 1'b1, a_sclr = 1'b1, a_load = 1'b1, a_enp = 1'b0, a_ent = 1'b0, a_up = 1'b1;
    logic [3:0] a_d = 4'd0;
    logic [3:0] a_q;
    logic       a_tc, a_co, a_wrap, a_ovf;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3)) dut_a (
        .CLK(clk), .MR(a_mr), .SCLR(a_sclr), .LOAD(a_load), .D(a_d),
        .ENP(a_enp), .ENT(a_ent), .UP(a_up),
        .Q(a_q), .TC(a_tc), .CO(a_co), .WRAP(a_wrap), .OVF(a_ovf)
    );

    // Two decimal stages, lower CO feeding upper ENT
    logic       cas_mr = 1'b1, cas_sclr = 1'b1, cas_load = 1'b1, cas_enp = 1'b0, cas_ent = 1'b1, cas_up = 1'b1;
    logic [3:0] cas_d = 4'd0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_wrap, lo_ovf;
    logic       hi_tc, hi_co, hi_wrap, hi_ovf;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_lo (
        .CLK(clk), .MR(cas_mr), .SCLR(cas_sclr), .LOAD(cas_load), .D(cas_d),
        .ENP(cas_enp), .ENT(cas_ent), .UP(cas_up),
        .Q(lo_q), .TC(lo_tc), .CO(lo_co), .WRAP(lo_wrap), .OVF(lo_ovf)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_hi (
        .CLK(clk), .MR(cas_mr), .SCLR(cas_sclr), .LOAD(cas_load), .D(cas_d),
        .ENP(cas_enp), .ENT(lo_co), .UP(cas_up),
        .Q(hi_q), .TC(hi_tc), .CO(hi_co), .WRAP(hi_wrap), .OVF(hi_ovf)
    );

    // Full-range 3-bit counter, RESET_VALUE 5
    logic       c_mr = 1'b1, c_sclr = 1'b1, c_load = 1'b1, c_enp = 1'b0, c_ent = 1'b0, c_up = 1'b1;
    logic [2:0] c_d = 3'd0;
    logic [2:0] c_q;
    logic       c_tc, c_co, c_wrap, c_ovf;

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(5)) dut_c (
        .CLK(clk), .MR(c_mr), .SCLR(c_sclr), .LOAD(c_load), .D(c_d),
        .ENP(c_enp), .ENT(c_ent), .UP(c_up),
        .Q(c_q), .TC(c_tc), .CO(c_co), .WRAP(c_wrap), .OVF(c_ovf)
    );

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checkValue({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            checkValue({tag, "_q"},    {4'd0, a_q}, {4'd0, e.q});
            checkValue({tag, "_wrap"}, {7'd0, a_wrap}, {7'd0, e.wrap});
            checkValue({tag, "_ovf"},  {7'd0, a_ovf}, {7'd0, e.ovf});
            checkValue({tag, "_tc"},   {7'd0, a_tc}, {7'd0, e.tc});
            checkValue({tag, "_co"},   {7'd0, a_co}, {7'd0, e.co});
        end
    endtask

    // Drives one clock's worth of controls on dut_a and queues the expected result.
    task automatic applyStimulus(input string tag,
                                 input logic sclr, input logic load, input logic [3:0] d,
                                 input logic enp, input logic ent, input logic up,
                                 input logic [3:0] eq, input logic ewrap, input logic eovf,
                                 input logic etc, input logic eco);
        exp_t e;
        a_sclr = sclr;
        a_load = load;
        a_d    = d;
        a_enp  = enp;
        a_ent  = ent;
        a_up   = up;
        e.q    = eq;
        e.wrap = ewrap;
        e.ovf  = eovf;
        e.tc   = etc;
        e.co   = eco;
        sb.push_back(e);
        cycle();
        checkOutput(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi_wraps;
        int lo_wraps;
        int value;

        // Asynchronous reset takes effect before the first clock edge.
        #1 a_mr = 1'b0;
        #2;
        checkValue("a_reset_q",    {4'd0, a_q}, 8'd3);
        checkValue("a_reset_wrap", {7'd0, a_wrap}, 8'd0);
        checkValue("a_reset_ovf",  {7'd0, a_ovf}, 8'd0);
        @(negedge clk);
        a_mr = 1'b1;

        //             tag          sclr  load  d      enp   ent   up    q      wrap  ovf   tc    co
        applyStimulus("hold",       1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("load7",      1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("up8",        1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("up9",        1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("up_wrap0",   1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("up1",        1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("down0",      1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus("down_wrap9", 1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("down8",      1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("load0_ent0", 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("hold_ent0",  1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("load_sat",   1'b1, 1'b0, 4'hC,  1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus("clr_beats",  1'b0, 1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1);

        // TC follows UP combinationally with no clock edge.
        a_sclr = 1'b1;
        a_load = 1'b1;
        a_enp  = 1'b0;
        a_up   = 1'b1;
        #1;
        checkValue("a_tc_up_flip", {7'd0, a_tc}, 8'd0);
        checkValue("a_co_up_flip", {7'd0, a_co}, 8'd0);

        // Two-stage decimal cascade: 100 counts from 00 back to 00.
        @(negedge clk);
        cas_mr = 1'b0;
        @(negedge clk);
        cas_mr  = 1'b1;
        cas_enp = 1'b1;
        hi_wraps = 0;
        lo_wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            if ((i - 1) % 10 == 9) begin
                checkValue($sformatf("cas_lo_co_at_%0d", i - 1), {7'd0, lo_co}, 8'd1);
            end
            cycle();
            value = int'(hi_q) * 10 + int'(lo_q);
            checkValue($sformatf("cas_value_%0d", i), 8'(value), 8'(i % 100));
            if (hi_wrap) hi_wraps++;
            if (lo_wrap) lo_wraps++;
        end
        checkValue("cas_hi_wrap_last", {7'd0, hi_wrap}, 8'd1);
        checkValue("cas_hi_wraps",     8'(hi_wraps), 8'd1);
        checkValue("cas_lo_wraps",     8'(lo_wraps), 8'd10);
        checkValue("cas_hi_ovf",       {7'd0, hi_ovf}, 8'd1);
        cas_enp = 1'b0;

        // Full binary range: wraps at 7 -> 0 and 0 -> 7.
        c_mr = 1'b0;
        #1;
        checkValue("c_reset_q", {5'd0, c_q}, 8'd5);
        @(negedge clk);
        c_mr   = 1'b1;
        c_load = 1'b0;
        c_d    = 3'd6;
        c_enp  = 1'b1;
        c_ent  = 1'b1;
        c_up   = 1'b1;
        cycle();
        checkValue("c_load6", {5'd0, c_q}, 8'd6);
        c_load = 1'b1;
        cycle();
        checkValue("c_up7",    {5'd0, c_q}, 8'd7);
        checkValue("c_up7_tc", {7'd0, c_tc}, 8'd1);
        cycle();
        checkValue("c_wrap0",      {5'd0, c_q}, 8'd0);
        checkValue("c_wrap0_wrap", {7'd0, c_wrap}, 8'd1);
        checkValue("c_wrap0_ovf",  {7'd0, c_ovf}, 8'd1);
        c_up = 1'b0;
        cycle();
        checkValue("c_down_wrap7",      {5'd0, c_q}, 8'd7);
        checkValue("c_down_wrap7_wrap", {7'd0, c_wrap}, 8'd1);
        cycle();
        checkValue("c_down6",      {5'd0, c_q}, 8'd6);
        checkValue("c_down6_wrap", {7'd0, c_wrap}, 8'd0);

        // Asynchronous reset mid-count overrides a pending load.
        c_load = 1'b0;
        c_d    = 3'd2;
        c_mr   = 1'b0;
        #1;
        checkValue("c_mr_mid_q",   {5'd0, c_q}, 8'd5);
        checkValue("c_mr_mid_ovf", {7'd0, c_ovf}, 8'd0);
        cycle();
        checkValue("c_mr_held_q",  {5'd0, c_q}, 8'd5);
        c_mr   = 1'b1;
        c_load = 1'b1;
        c_enp  = 1'b0;
        cycle();
        checkValue("c_after_mr_hold", {5'd0, c_q}, 8'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
